// File: rtl/md_unit_if.sv
// md_unit_if: issue/result bundle between the issuing pipeline stage and
// the multiply/divide unit.
//   start, md_op, in1, in2, flush : issue side, driven by the pipeline
//   busy, done, hi_out, lo_out     : unit status and architectural HI/LO
//   dbg_state                      : 1 while the unit is in RUN
// Handshake: an op is taken on a rising edge where start=1, flush=0 and the
// unit is idle; any other start is dropped. busy covers the whole timed
// execution, done pulses for one cycle when HI/LO take the new result.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             dbg_state;

  modport master (
    output start, md_op, in1, in2, flush,
    input  busy, done, hi_out, lo_out, dbg_state
  );

  modport slave (
    input  start, md_op, in1, in2, flush,
    output busy, done, hi_out, lo_out, dbg_state
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit.
// Timed ops (mult, multu, madd, msub, div, divu) occupy the unit for a fixed
// number of cycles and commit HI/LO on the final edge; mthi/mtlo write one
// register directly while idle.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : md_unit_if slave modport (issue inputs, busy/done, HI/LO, debug)
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MSUB  = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // ------------------------------------------------------------------
  // Result datapath, evaluated from the operands latched at acceptance.
  // HI/LO cannot change during RUN, so hi_q/lo_q are the accumulator
  // values captured at acceptance for madd/msub.
  // ------------------------------------------------------------------
  logic [2*WIDTH-1:0] sprod, uprod, acc, result;
  logic               a_neg, b_neg, div_by_zero, commit_en;
  logic [WIDTH-1:0]   ua, ub, udiv, uq, ur, q_s, r_s;

  always_comb begin
    sprod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    uprod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    acc   = {hi_q, lo_q};

    // Signed division works on magnitudes and fixes signs afterwards.
    // The most-negative / -1 case falls out naturally: the quotient
    // magnitude 2^(WIDTH-1) negates back to the most-negative value and the
    // remainder is 0.
    a_neg       = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg       = (op_q == OP_DIV) && b_q[WIDTH-1];
    ua          = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    ub          = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    div_by_zero = (b_q == '0);
    // Substitute a divisor of 1 on zero so the divider never sees x/0;
    // the result is discarded in that case anyway.
    udiv        = div_by_zero ? WIDTH'(1) : ub;
    uq          = ua / udiv;
    ur          = ua % udiv;
    q_s         = (a_neg ^ b_neg) ? (~uq + WIDTH'(1)) : uq;
    r_s         = a_neg ? (~ur + WIDTH'(1)) : ur;

    result    = acc;
    commit_en = 1'b1;
    case (op_q)
      OP_MULT:  result = sprod;
      OP_MULTU: result = uprod;
      OP_MADD:  result = acc + sprod;
      OP_MSUB:  result = acc - sprod;
      OP_DIV, OP_DIVU: begin
        result    = {r_s, q_s};
        commit_en = !div_by_zero;
      end
      default: commit_en = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // Control FSM: next state, counter, operand latches, HI/LO writes.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.md_op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              op_d    = bus.md_op;
              a_d     = bus.in1;
              b_d     = bus.in2;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = bus.md_op;
              a_d     = bus.in1;
              b_d     = bus.in2;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.in1;
            OP_MTLO: lo_d = bus.in1;
            default: ;  // none / undefined: no-op
          endcase
        end
      end

      RUN: begin
        if (bus.flush) begin
          // Killed op: drop back without touching HI/LO or pulsing done.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          // Final edge: commit, pulse done, release busy together.
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (commit_en) begin
            hi_d = result[2*WIDTH-1:WIDTH];
            lo_d = result[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MSUB  = 4'b1000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge: inputs are driven and
  // outputs sampled here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.flush = 1'b0;
  endtask

  // Present one op for exactly one edge (the accepting edge, "edge 0").
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.in1   = a;
    bus.in2   = b;
    tick();
    idle_inputs();
  endtask

  // Count edges until busy drops (bounded); reports whether done rose early.
  task automatic run_to_done(input int n_start, output int n, output bit early_done);
    n = n_start;
    early_done = 1'b0;
    while (bus.busy && n < 200) begin
      if (bus.done) early_done = 1'b1;
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.md_op = OP_MTHI;
    bus.in1   = 32'hDEADBEEF;
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", bus.lo_out); end
    checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b want 0", bus.dbg_state); end
  endtask

  task automatic test_mult();
    int n; bit early;
    issue(OP_MULT, 32'hFFFFFFFF, 32'h00000002);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy_start got %b want 1", bus.busy); end
    checks++; if (bus.dbg_state !== 1'b1) begin errors++; $display("FAIL mult_state_run got %b want 1", bus.dbg_state); end
    checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL mult_hi_hold got %h want 00000000", bus.hi_out); end
    run_to_done(0, n, early);
    checks++; if (n !== MC) begin errors++; $display("FAIL mult_cycles got %0d want %0d", n, MC); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL mult_early_done got %b want 0", early); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mult_done got %b want 1", bus.done); end
    checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", bus.lo_out); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_multu();
    int n; bit early;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
    run_to_done(0, n, early);
    checks++; if (n !== MC) begin errors++; $display("FAIL multu_cycles got %0d want %0d", n, MC); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL multu_done got %b want 1", bus.done); end
    checks++; if (bus.hi_out !== 32'h00000001) begin errors++; $display("FAIL multu_hi got %h want 00000001", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", bus.lo_out); end
    tick();
  endtask

  task automatic test_div();
    int n; bit early;
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    run_to_done(0, n, early);
    checks++; if (n !== DC) begin errors++; $display("FAIL div_cycles got %0d want %0d", n, DC); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL div_done got %b want 1", bus.done); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo_out); end
    checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi_out); end
    tick();
  endtask

  task automatic test_divu_zero();
    int n; bit early;
    issue(OP_DIVU, 32'h00000007, 32'h00000000);
    run_to_done(0, n, early);
    checks++; if (n !== DC) begin errors++; $display("FAIL divz_cycles got %0d want %0d", n, DC); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL divz_done got %b want 1", bus.done); end
    checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_hi got %h want ffffffff", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL divz_lo got %h want fffffffd", bus.lo_out); end
    tick();
  endtask

  task automatic test_div_min();
    int n; bit early;
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_to_done(0, n, early);
    checks++; if (bus.lo_out !== 32'h80000000) begin errors++; $display("FAIL divmin_lo got %h want 80000000", bus.lo_out); end
    checks++; if (bus.hi_out !== 32'h00000000) begin errors++; $display("FAIL divmin_hi got %h want 00000000", bus.hi_out); end
    tick();
    // divu of the same bit patterns: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
    issue(OP_DIVU, 32'h80000000, 32'hFFFFFFFF);
    run_to_done(0, n, early);
    checks++; if (bus.lo_out !== 32'h00000000) begin errors++; $display("FAIL divu_big_lo got %h want 00000000", bus.lo_out); end
    checks++; if (bus.hi_out !== 32'h80000000) begin errors++; $display("FAIL divu_big_hi got %h want 80000000", bus.hi_out); end
    tick();
  endtask

  task automatic test_flush();
    logic [W-1:0] hi0, lo0;
    hi0 = 32'h80000000;  // left by test_div_min
    lo0 = 32'h00000000;
    issue(OP_MULT, 32'h00000003, 32'h00000004);   // now after edge 0
    tick();                                       // after edge 1
    tick();                                       // after edge 2
    bus.flush = 1'b1;
    tick();                                       // after edge 3
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", bus.done); end
    tick();
    tick();
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done_late got %b want 0", bus.done); end
    checks++; if (bus.hi_out !== hi0) begin errors++; $display("FAIL flush_hi got %h want %h", bus.hi_out, hi0); end
    checks++; if (bus.lo_out !== lo0) begin errors++; $display("FAIL flush_lo got %h want %h", bus.lo_out, lo0); end
  endtask

  task automatic test_ignore_busy();
    int n; bit early;
    issue(OP_DIV, 32'd100, 32'd7);                // after edge 0
    bus.start = 1'b1; bus.md_op = OP_DIV;  bus.in1 = 32'd5; bus.in2 = 32'd1;
    tick();                                       // after edge 1
    bus.start = 1'b1; bus.md_op = OP_MTHI; bus.in1 = 32'h12345678;
    tick();                                       // after edge 2
    idle_inputs();
    checks++; if (bus.hi_out !== 32'h80000000) begin errors++; $display("FAIL ign_mthi_busy got %h want 80000000", bus.hi_out); end
    run_to_done(2, n, early);
    checks++; if (n !== DC) begin errors++; $display("FAIL ign_cycles got %0d want %0d", n, DC); end
    checks++; if (bus.lo_out !== 32'd14) begin errors++; $display("FAIL ign_lo got %h want 0000000e", bus.lo_out); end
    checks++; if (bus.hi_out !== 32'd2) begin errors++; $display("FAIL ign_hi got %h want 00000002", bus.hi_out); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_relaunch got %b want 0", bus.busy); end
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'h12345678, 32'h0);
    checks++; if (bus.hi_out !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'd14) begin errors++; $display("FAIL mthi_lo got %h want 0000000e", bus.lo_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b want 0", bus.done); end
    // start with flush in IDLE is dropped
    bus.start = 1'b1; bus.md_op = OP_MTLO; bus.in1 = 32'hCAFEF00D; bus.flush = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.lo_out !== 32'd14) begin errors++; $display("FAIL flush_idle_lo got %h want 0000000e", bus.lo_out); end
    // undefined op code is a no-op
    issue(4'b1111, 32'h55555555, 32'h1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL undef_busy got %b want 0", bus.busy); end
    checks++; if (bus.hi_out !== 32'h12345678) begin errors++; $display("FAIL undef_hi got %h want 12345678", bus.hi_out); end
  endtask

  task automatic test_madd_msub();
    int n; bit early;
    issue(OP_MTHI, 32'h00000000, 32'h0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    issue(OP_MADD, 32'h00000001, 32'h00000001);
    run_to_done(0, n, early);
    checks++; if (n !== MC) begin errors++; $display("FAIL madd_cycles got %0d want %0d", n, MC); end
    checks++; if (bus.hi_out !== 32'h00000001) begin errors++; $display("FAIL madd_hi got %h want 00000001", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'h00000000) begin errors++; $display("FAIL madd_lo got %h want 00000000", bus.lo_out); end
    tick();
    // 0x1_00000000 - 6 = 0x0_FFFFFFFA
    issue(OP_MSUB, 32'h00000002, 32'h00000003);
    run_to_done(0, n, early);
    checks++; if (bus.hi_out !== 32'h00000000) begin errors++; $display("FAIL msub_hi got %h want 00000000", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL msub_lo got %h want fffffffa", bus.lo_out); end
    tick();
  endtask

  task automatic test_commit_edge_start();
    issue(OP_MULTU, 32'h00000010, 32'h00000010);  // after edge 0, product 0x100
    tick(); tick(); tick();                       // after edge 3
    tick();                                       // after edge 4
    bus.start = 1'b1; bus.md_op = OP_MTHI; bus.in1 = 32'hAAAAAAAA;
    tick();                                       // after edge 5 (commit)
    idle_inputs();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL cedge_done got %b want 1", bus.done); end
    checks++; if (bus.hi_out !== 32'h00000000) begin errors++; $display("FAIL cedge_hi got %h want 00000000", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'h00000100) begin errors++; $display("FAIL cedge_lo got %h want 00000100", bus.lo_out); end
    tick();
    checks++; if (bus.hi_out !== 32'h00000000) begin errors++; $display("FAIL cedge_hi_late got %h want 00000000", bus.hi_out); end
  endtask

  task automatic test_reset_mid_op();
    int n; bit early;
    issue(OP_DIV, 32'd50, 32'd3);                 // after edge 0
    tick();                                       // after edge 1
    reset = 1'b1;
    bus.start = 1'b1; bus.md_op = OP_MTHI; bus.in1 = 32'h77777777; bus.flush = 1'b1;
    tick();                                       // after edge 2
    reset = 1'b0;
    idle_inputs();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", bus.done); end
    checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL rmid_hi got %h want 00000000", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'h0) begin errors++; $display("FAIL rmid_lo got %h want 00000000", bus.lo_out); end
    issue(OP_MULT, 32'h00000003, 32'hFFFFFFFE);   // 3 * -2 = -6
    run_to_done(0, n, early);
    checks++; if (n !== MC) begin errors++; $display("FAIL rmid_mult_cycles got %0d want %0d", n, MC); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rmid_mult_done got %b want 1", bus.done); end
    checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL rmid_mult_hi got %h want ffffffff", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL rmid_mult_lo got %h want fffffffa", bus.lo_out); end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_div_min();
    test_flush();
    test_ignore_busy();
    test_mthi_mtlo();
    test_madd_msub();
    test_commit_edge_start();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so a wedged run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand and HI/LO register width in bits (>=8).
REQ-002 SHALL have parameter MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, 10, busy cycles for div/divu (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  issue strobe for md_op, sampled each edge.
REQ-007 SHALL have port md_op  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 msub; others = none.
REQ-008 SHALL have port in1  input  WIDTH  rs operand / dividend / mthi-mtlo source.
REQ-009 SHALL have port in2  input  WIDTH  rt operand / divisor.
REQ-010 SHALL have port flush  input  1  abort in-flight op (exception/interrupt kill).
REQ-011 SHALL have port busy  output  1  op in flight; issuing stage stalls on it.
REQ-012 SHALL have port done  output  1  one-cycle pulse on HI/LO commit of a timed op.
REQ-013 SHALL have ports hi_out, lo_out  output  WIDTH each  architectural HI/LO.

Function
REQ-014 SHALL implement states IDLE and RUN with a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 SHALL accept an op only when start=1, flush=0, state=IDLE; all other starts SHALL be ignored without side effects.
REQ-016 SHALL, on accepting a timed op at edge t, latch in1, in2, md_op, enter RUN, assert busy from after edge t for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 SHALL commit HI/LO, pulse done, drop busy, and return to IDLE on the same edge, N edges after acceptance; hi_out/lo_out SHALL show the new value in the cycle busy is first low.
REQ-018 SHALL keep hi_out/lo_out at pre-op values throughout RUN.
REQ-019 SHALL compute mult as signed and multu as unsigned 2*WIDTH-bit product, {HI,LO} = product.
REQ-020 SHALL compute madd/msub as {HI,LO} +/- signed product, modulo 2^(2*WIDTH), using HI/LO as latched at acceptance.
REQ-021 SHALL compute div signed: LO = quotient truncated toward zero, HI = remainder with dividend sign; divu unsigned.
REQ-022 SHALL, for signed div of most-negative value by -1, set LO = most-negative value, HI = 0.
REQ-023 SHALL, for div/divu with in2 = 0, run full DIV_CYCLES, pulse done, and leave HI/LO unchanged.
REQ-024 SHALL execute mthi/mtlo in IDLE with no busy: HI (resp. LO) = in1 at the accepting edge, other register unchanged, no done pulse.
REQ-025 SHALL, on flush=1 in RUN, return to IDLE at that edge, drop busy next cycle, not commit, not pulse done; HI/LO keep pre-op values.
REQ-026 SHALL, on flush=1 with start=1 in IDLE, ignore the start (no mthi/mtlo write, no op launched).
REQ-027 SHALL, with start=1 on the commit edge, ignore that start; a new op is accepted no earlier than the next edge.
REQ-028 SHALL treat md_op = none or undefined with start=1 as a no-op.

Reset
REQ-029 SHALL, when reset=1 at an edge, set state IDLE, counter 0, busy=0, done=0, hi_out=0, lo_out=0, regardless of start/flush or in-flight op.
REQ-030 SHALL give reset priority over flush and start in the same cycle.

Verification
REQ-031 SHALL verify mult: WIDTH=32, MULT_CYCLES=5, in1=0xFFFFFFFF, in2=0x00000002, start at edge 0 -> busy high 5 cycles, done at edge 5, HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL verify div: in1=0xFFFFFFF9 (-7), in2=2, DIV_CYCLES=10 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged, done pulses.
REQ-033 SHALL verify flush: start mult at edge 0, flush at edge 3 -> busy low from edge 3, no done, HI/LO equal pre-op values.
REQ-034 SHALL verify ignore rules: start div while busy -> no effect on result or timing; mthi 0x12345678 while busy -> HI unchanged; mthi in IDLE -> HI=0x12345678 next cycle, busy stays 0.
REQ-035 SHALL verify madd: HI=0, LO=0xFFFFFFFF, madd 1*1 -> HI=0x00000001, LO=0x00000000.
REQ-036 SHALL verify reset mid-op: reset at edge 2 of div -> busy=0, done=0, HI=LO=0 next cycle; fresh mult then completes normally.
